// File: rtl/ix_execute_stage_if.sv
// ix_execute_stage_if: ID/IX inputs and IX/MEM outputs of the execute stage.
interface ix_execute_stage_if;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] ir_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [5:0]  alu_op_in;
    logic        is_branch_in;
    logic        op2_sel_in;
    logic [5:0]  shift_amount_in;
    logic        stall;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] ir_out;
    logic [31:0] result_out;
    logic [31:0] B_out;
    logic        branch_taken;
    logic [31:0] branch_target;

    modport slave (
        input  in_valid, pc_in, ir_in, A_in, B_in, alu_op_in, is_branch_in, op2_sel_in, shift_amount_in,
        output stall, out_valid, pc_out, ir_out, result_out, B_out, branch_taken, branch_target
    );

    modport master (
        output in_valid, pc_in, ir_in, A_in, B_in, alu_op_in, is_branch_in, op2_sel_in, shift_amount_in,
        input  stall, out_valid, pc_out, ir_out, result_out, B_out, branch_taken, branch_target
    );
endinterface

// File: rtl/ix_execute_stage.sv
// ix_execute_stage: execute stage with registered ALU/branch results and a multi-cycle MULT/DIV unit on HI/LO.
module ix_execute_stage #(
    parameter int MD_LATENCY = 32
) (
    input logic clk,
    input logic reset,
    ix_execute_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;
    localparam int CW = MD_LATENCY > 1 ? $clog2(MD_LATENCY) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          md_signed_q, md_signed_d;
    logic [31:0]   md_a_q, md_a_d, md_b_q, md_b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   pc_q, pc_d, ir_q, ir_d, result_q, result_d, b_q, b_d, target_q, target_d;
    logic          taken_q, taken_d;

    logic [31:0] imm_sext, op2, alu;
    logic [4:0]  sh;
    logic        accept, taken, is_mul, is_div, unused_sh;
    logic [63:0] mul;
    logic        a_neg, b_neg;
    logic [31:0] ua, ub, ub_safe, uq, ur, div_q, div_r;

    assign imm_sext  = {{16{bus.ir_in[15]}}, bus.ir_in[15:0]};
    assign op2       = bus.op2_sel_in ? imm_sext : bus.B_in;
    assign sh        = bus.shift_amount_in[4:0];
    assign unused_sh = bus.shift_amount_in[5];
    assign bus.stall = (state_q != IDLE) & bus.in_valid;
    assign accept    = bus.in_valid & ~bus.stall;
    assign is_mul    = bus.alu_op_in == 6'd11 || bus.alu_op_in == 6'd12;
    assign is_div    = bus.alu_op_in == 6'd13 || bus.alu_op_in == 6'd14;
    assign taken     = bus.is_branch_in & (bus.alu_op_in == 6'd17 ? bus.A_in == bus.B_in :
                                           bus.alu_op_in == 6'd18 ? bus.A_in != bus.B_in : 1'b0);

    always_comb begin
        alu = '0;
        case (bus.alu_op_in)
            6'd0:    alu = bus.A_in + op2;
            6'd1:    alu = bus.A_in - op2;
            6'd2:    alu = bus.A_in & op2;
            6'd3:    alu = bus.A_in | op2;
            6'd4:    alu = bus.A_in ^ op2;
            6'd5:    alu = ~(bus.A_in | op2);
            6'd6:    alu = {31'h0, $signed(bus.A_in) < $signed(op2)};
            6'd7:    alu = {31'h0, bus.A_in < op2};
            6'd8:    alu = op2 << sh;
            6'd9:    alu = op2 >> sh;
            6'd10:   alu = $signed(op2) >>> sh;
            6'd15:   alu = hi_q;
            6'd16:   alu = lo_q;
            6'd19:   alu = {bus.ir_in[15:0], 16'h0};
            default: alu = '0;
        endcase
    end

    // Operands stay latched for the whole busy window, so these paths have MD_LATENCY cycles to settle.
    assign mul     = {{32{md_signed_q & md_a_q[31]}}, md_a_q} * {{32{md_signed_q & md_b_q[31]}}, md_b_q};
    assign a_neg   = md_signed_q & md_a_q[31];
    assign b_neg   = md_signed_q & md_b_q[31];
    assign ua      = a_neg ? -md_a_q : md_a_q;
    assign ub      = b_neg ? -md_b_q : md_b_q;
    assign ub_safe = ub == '0 ? 32'd1 : ub;
    assign uq      = ua / ub_safe;
    assign ur      = ua % ub_safe;
    assign div_q   = md_b_q == '0 ? 32'hFFFF_FFFF : (a_neg ^ b_neg) ? -uq : uq;
    assign div_r   = md_b_q == '0 ? md_a_q : a_neg ? -ur : ur;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_signed_d = md_signed_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = accept;
        pc_d        = accept ? bus.pc_in : pc_q;
        ir_d        = accept ? bus.ir_in : ir_q;
        result_d    = accept ? alu : result_q;
        b_d         = accept ? bus.B_in : b_q;
        taken_d     = accept ? taken : taken_q;
        target_d    = accept ? bus.pc_in + 32'd4 + {imm_sext[29:0], 2'b00} : target_q;
        if (state_q == IDLE && accept && (is_mul || is_div)) begin
            state_d     = is_mul ? MUL_BUSY : DIV_BUSY;
            cnt_d       = CW'(MD_LATENCY - 1);
            md_signed_d = bus.alu_op_in == 6'd11 || bus.alu_op_in == 6'd13;
            md_a_d      = bus.A_in;
            md_b_d      = op2;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
                hi_d    = state_q == MUL_BUSY ? mul[63:32] : div_r;
                lo_d    = state_q == MUL_BUSY ? mul[31:0] : div_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            md_signed_q <= 1'b0;
            md_a_q      <= '0;
            md_b_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            ir_q        <= '0;
            result_q    <= '0;
            b_q         <= '0;
            taken_q     <= 1'b0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_signed_q <= md_signed_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            result_q    <= result_d;
            b_q         <= b_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.pc_out        = pc_q;
    assign bus.ir_out        = ir_q;
    assign bus.result_out    = result_q;
    assign bus.B_out         = b_q;
    assign bus.branch_taken  = taken_q;
    assign bus.branch_target = target_q;
endmodule

// File: tb/tb_ix_execute_stage.sv
// tb_ix_execute_stage: directed and random instructions checked against an arithmetic model of the execute stage.
module tb_ix_execute_stage;
    localparam int MD = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_busy = 0;
    int   last_stall_n = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    ix_execute_stage_if bus();
    ix_execute_stage #(.MD_LATENCY(MD)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_tick();
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        #1;
        check("stall_no_valid", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        check("ov_idle", 32'(bus.out_valid), 32'd0);
        model_tick();
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] ir, input logic sel, input logic isbr, input logic [5:0] sh);
        logic [31:0] imm, op2, exp_res;
        logic [4:0]  s;
        logic        exp_tk;
        longint      sp, sq, sr;
        logic [63:0] up;
        bus.in_valid        = 1'b1;
        bus.alu_op_in       = op;
        bus.A_in            = a;
        bus.B_in            = b;
        bus.pc_in           = pc;
        bus.ir_in           = ir;
        bus.op2_sel_in      = sel;
        bus.is_branch_in    = isbr;
        bus.shift_amount_in = sh;
        last_stall_n = 0;
        while (m_busy > 0) begin
            #1;
            check("stall_busy", 32'(bus.stall), 32'd1);
            @(posedge clk);
            #1;
            check("ov_busy", 32'(bus.out_valid), 32'd0);
            model_tick();
            last_stall_n++;
        end
        #1;
        check("stall_idle", 32'(bus.stall), 32'd0);
        imm = {{16{ir[15]}}, ir[15:0]};
        op2 = sel ? imm : b;
        s   = sh[4:0];
        exp_res = 32'd0;
        case (op)
            6'd0:  exp_res = a + op2;
            6'd1:  exp_res = a - op2;
            6'd2:  exp_res = a & op2;
            6'd3:  exp_res = a | op2;
            6'd4:  exp_res = a ^ op2;
            6'd5:  exp_res = ~(a | op2);
            6'd6:  exp_res = (int'(a) < int'(op2)) ? 32'd1 : 32'd0;
            6'd7:  exp_res = (a < op2) ? 32'd1 : 32'd0;
            6'd8:  exp_res = op2 << s;
            6'd9:  exp_res = op2 >> s;
            6'd10: exp_res = 32'(int'(op2) >>> s);
            6'd15: exp_res = m_hi;
            6'd16: exp_res = m_lo;
            6'd19: exp_res = {ir[15:0], 16'h0};
            default: exp_res = 32'd0;
        endcase
        exp_tk = isbr && ((op == 6'd17 && a == b) || (op == 6'd18 && a != b));
        if (op >= 6'd11 && op <= 6'd14) begin
            m_busy = MD;
            if (op == 6'd11) begin
                sp = longint'(int'(a)) * longint'(int'(op2));
                up = 64'(sp);
                {p_hi, p_lo} = up;
            end else if (op == 6'd12) begin
                up = 64'(a) * 64'(op2);
                {p_hi, p_lo} = up;
            end else if (op2 == 32'd0) begin
                p_lo = 32'hFFFF_FFFF;
                p_hi = a;
            end else if (op == 6'd13) begin
                sq = longint'(int'(a)) / longint'(int'(op2));
                sr = longint'(int'(a)) % longint'(int'(op2));
                p_lo = 32'(sq);
                p_hi = 32'(sr);
            end else begin
                p_lo = a / op2;
                p_hi = a % op2;
            end
        end
        @(posedge clk);
        #1;
        check("ov_accept", 32'(bus.out_valid), 32'd1);
        check($sformatf("result_op%0d", op), bus.result_out, exp_res);
        check("pc_out", bus.pc_out, pc);
        check("ir_out", bus.ir_out, ir);
        check("b_out", bus.B_out, b);
        check($sformatf("taken_op%0d", op), 32'(bus.branch_taken), 32'(exp_tk));
        check("target", bus.branch_target, pc + 32'd4 + (imm << 2));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b;
        bus.in_valid = 1'b1;
        bus.alu_op_in = 6'd0;
        bus.A_in = '0;
        bus.B_in = '0;
        bus.pc_in = 32'h40;
        bus.ir_in = 32'h1234;
        bus.op2_sel_in = 1'b0;
        bus.is_branch_in = 1'b0;
        bus.shift_amount_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_result", bus.result_out, 32'd0);
        check("rst_target", bus.branch_target, 32'd0);
        check("rst_pc", bus.pc_out, 32'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        idle_cycle();
        issue(6'd19, 32'd0, 32'd0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 6'd0);
        issue(6'd15, 32'd0, 32'd0, 32'h4, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd16, 32'd0, 32'd0, 32'h8, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd0, 32'd7, 32'd5, 32'h10, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd1, 32'd5, 32'd7, 32'h14, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd6, 32'hFFFF_FFFF, 32'd1, 32'h18, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd7, 32'hFFFF_FFFF, 32'd1, 32'h1C, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd10, 32'd0, 32'h8000_0000, 32'h20, 32'h0, 1'b0, 1'b0, 6'd4);
        issue(6'd8, 32'd0, 32'h1, 32'h24, 32'h0, 1'b0, 1'b0, 6'd63);
        issue(6'd17, 32'd3, 32'd3, 32'h100, 32'h0000_FFFF, 1'b0, 1'b1, 6'd0);
        check("beq_target_abs", bus.branch_target, 32'h100);
        issue(6'd18, 32'd3, 32'd3, 32'h100, 32'h0000_FFFF, 1'b0, 1'b1, 6'd0);
        issue(6'd17, 32'd3, 32'd3, 32'h100, 32'h0000_0010, 1'b1, 1'b1, 6'd0);
        issue(6'd11, 32'hFFFF_FFFD, 32'd4, 32'h200, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd15, 32'd0, 32'd0, 32'h204, 32'h0, 1'b0, 1'b0, 6'd0);
        check("mult_stall_cycles", 32'(last_stall_n), 32'(MD));
        check("mult_hi", bus.result_out, 32'hFFFF_FFFF);
        issue(6'd16, 32'd0, 32'd0, 32'h208, 32'h0, 1'b0, 1'b0, 6'd0);
        check("mult_lo", bus.result_out, 32'hFFFF_FFF4);
        issue(6'd13, 32'hFFFF_FFF9, 32'd2, 32'h300, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd16, 32'd0, 32'd0, 32'h304, 32'h0, 1'b0, 1'b0, 6'd0);
        check("div_lo", bus.result_out, 32'hFFFF_FFFD);
        issue(6'd15, 32'd0, 32'd0, 32'h308, 32'h0, 1'b0, 1'b0, 6'd0);
        check("div_hi", bus.result_out, 32'hFFFF_FFFF);
        issue(6'd14, 32'd5, 32'd0, 32'h30C, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd16, 32'd0, 32'd0, 32'h310, 32'h0, 1'b0, 1'b0, 6'd0);
        check("divz_lo", bus.result_out, 32'hFFFF_FFFF);
        issue(6'd15, 32'd0, 32'd0, 32'h314, 32'h0, 1'b0, 1'b0, 6'd0);
        check("divz_hi", bus.result_out, 32'd5);
        issue(6'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h318, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd16, 32'd0, 32'd0, 32'h31C, 32'h0, 1'b0, 1'b0, 6'd0);
        check("divovf_lo", bus.result_out, 32'h8000_0000);
        issue(6'd15, 32'd0, 32'd0, 32'h320, 32'h0, 1'b0, 1'b0, 6'd0);
        check("divovf_hi", bus.result_out, 32'd0);
        issue(6'd14, 32'd100, 32'd7, 32'h400, 32'h0, 1'b0, 1'b0, 6'd0);
        repeat (10) idle_cycle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_busy = 0;
        m_hi = '0;
        m_lo = '0;
        bus.in_valid = 1'b1;
        bus.alu_op_in = 6'd16;
        #1;
        check("abort_stall", 32'(bus.stall), 32'd0);
        check("abort_ov", 32'(bus.out_valid), 32'd0);
        issue(6'd16, 32'd0, 32'd0, 32'h404, 32'h0, 1'b0, 1'b0, 6'd0);
        check("abort_lo", bus.result_out, 32'd0);
        issue(6'd15, 32'd0, 32'd0, 32'h408, 32'h0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 120; i++) begin
            op = 6'($urandom_range(0, 21));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = a;
                default: b = $urandom;
            endcase
            issue(op, a, b, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, 1'($urandom_range(0, 3) == 0),
                  (op == 6'd17 || op == 6'd18) ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 7) == 0),
                  6'($urandom_range(0, 63)));
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        while (m_busy > 0) idle_cycle();
        issue(6'd15, 32'd0, 32'd0, 32'h500, 32'h0, 1'b0, 1'b0, 6'd0);
        issue(6'd16, 32'd0, 32'd0, 32'h504, 32'h0, 1'b0, 1'b0, 6'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
